// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: RISC-V opcodes,
// forwarding select encodings, FSM states and the load-stall counter width.
package hazard_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Wide enough for LOAD_LATENCY-1 with the legal range 1..4.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_FREEZE   = 2'b10
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one EX source operand; the youngest producer
// (EX/MEM) wins over MEM/WB, and register 0 never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] i_rs,
    input  logic [AW-1:0] i_rd_mem,
    input  logic          i_regwrite_mem,
    input  logic [AW-1:0] i_rd_wb,
    input  logic          i_regwrite_wb,
    output fwd_sel_e      o_sel
);

    logic w_rs_nz;

    assign w_rs_nz = (i_rs != '0);

    always_comb begin
        // NOTE: combinational blocks assign a default first so no path can infer a latch.
        o_sel = FWD_RF;
        if (i_regwrite_mem && w_rs_nz && (i_rd_mem == i_rs)) begin
            o_sel = FWD_MEM;
        end else if (i_regwrite_wb && w_rs_nz && (i_rd_wb == i_rs)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall FSM, branch/jump flush
// and external freeze. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int  no_of_registers = 32,
    parameter int  LOAD_LATENCY    = 1,
    localparam int AW              = $clog2(no_of_registers)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs1_id,
    input  logic [AW-1:0] rs2_id,
    input  logic [AW-1:0] rs1_ex,
    input  logic [AW-1:0] rs2_ex,
    input  logic [AW-1:0] rd_ex,
    input  logic [AW-1:0] rd_mem,
    input  logic [AW-1:0] rd_wb,
    input  logic          regwrite_mem,
    input  logic          regwrite_wb,
    input  logic [6:0]    from_IMEM_ID_EX,
    input  logic [6:0]    from_IMEM_EX_MEM,
    input  logic          from_assertion,
    input  logic          ext_stall,
    output logic          stall,
    output logic          bubble_ex,
    output logic          flush_if_id,
    output logic          flush_id_ex,
    output logic          flush_ex_mem,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
);

    hz_state_e        r_state, r_saved_state;
    logic [CNT_W-1:0] r_cnt;

    hz_state_e        w_state_nxt, w_saved_nxt, w_eff_state;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_kill, w_jump, w_load_use;
    logic             w_stall, w_bubble, w_fl_if_id, w_fl_id_ex, w_fl_ex_mem;
    fwd_sel_e         w_fwd_a, w_fwd_b;

    hazard_fwd_sel #(.AW(AW)) u_fwd_a (
        .i_rs          (rs1_ex),
        .i_rd_mem      (rd_mem),
        .i_regwrite_mem(regwrite_mem),
        .i_rd_wb       (rd_wb),
        .i_regwrite_wb (regwrite_wb),
        .o_sel         (w_fwd_a)
    );

    hazard_fwd_sel #(.AW(AW)) u_fwd_b (
        .i_rs          (rs2_ex),
        .i_rd_mem      (rd_mem),
        .i_regwrite_mem(regwrite_mem),
        .i_rd_wb       (rd_wb),
        .i_regwrite_wb (regwrite_wb),
        .o_sel         (w_fwd_b)
    );

    assign w_kill     = (from_IMEM_EX_MEM == OP_BRANCH) && from_assertion;
    assign w_jump     = (from_IMEM_ID_EX == OP_JAL) || (from_IMEM_ID_EX == OP_JALR);
    assign w_load_use = (from_IMEM_ID_EX == OP_LOAD) && (rd_ex != '0) &&
                        ((rd_ex == rs1_id) || (rd_ex == rs2_id));

    // FREEZE behaves as the state it interrupted once ext_stall drops.
    assign w_eff_state = (r_state == ST_FREEZE) ? r_saved_state : r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_fl_if_id  = 1'b0;
        w_fl_id_ex  = 1'b0;
        w_fl_ex_mem = 1'b0;

        if (ext_stall) begin
            w_state_nxt = ST_FREEZE;
            w_saved_nxt = w_eff_state;
            w_stall     = 1'b1;
        end else if (w_kill) begin
            w_fl_if_id  = 1'b1;
            w_fl_id_ex  = 1'b1;
            w_fl_ex_mem = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_jump) begin
            w_fl_if_id  = 1'b1;
            w_fl_id_ex  = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (w_eff_state)
                ST_LD_STALL: begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_LD_STALL;
                        w_cnt_nxt   = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    if (w_load_use) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                        if (LOAD_LATENCY > 1) begin
                            w_state_nxt = ST_LD_STALL;
                            w_cnt_nxt   = CNT_W'(LOAD_LATENCY - 1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state       <= ST_IDLE;
            r_saved_state <= ST_IDLE;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_saved_state <= w_saved_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    // Outputs are combinational, so reset masks them to guarantee a quiet pipeline.
    assign stall        = w_stall     & ~reset;
    assign bubble_ex    = w_bubble    & ~reset;
    assign flush_if_id  = w_fl_if_id  & ~reset;
    assign flush_id_ex  = w_fl_id_ex  & ~reset;
    assign flush_ex_mem = w_fl_ex_mem & ~reset;
    assign fwd_a        = reset ? FWD_RF : w_fwd_a;
    assign fwd_b        = reset ? FWD_RF : w_fwd_b;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_fl_if_id && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with LOAD_LATENCY=3; counter expectations
// follow HAZARD_PERF_CNT_EN when the bench is built with it.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int LL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic          regwrite_mem, regwrite_wb;
    logic [6:0]    from_IMEM_ID_EX, from_IMEM_EX_MEM;
    logic          from_assertion, ext_stall;
    logic          stall, bubble_ex, flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]    fwd_a, fwd_b;
    logic [31:0]   stall_cnt, flush_cnt;

    logic [8:0]    obs;
    logic [8:0]    sb[$];
    logic [31:0]   m_stall_cnt, m_flush_cnt;
    int            total = 0;
    int            bad   = 0;

    hazard_ctrl #(.no_of_registers(32), .LOAD_LATENCY(LL)) dut (
        .clk             (clk),
        .reset           (reset),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rs1_ex          (rs1_ex),
        .rs2_ex          (rs2_ex),
        .rd_ex           (rd_ex),
        .rd_mem          (rd_mem),
        .rd_wb           (rd_wb),
        .regwrite_mem    (regwrite_mem),
        .regwrite_wb     (regwrite_wb),
        .from_IMEM_ID_EX (from_IMEM_ID_EX),
        .from_IMEM_EX_MEM(from_IMEM_EX_MEM),
        .from_assertion  (from_assertion),
        .ext_stall       (ext_stall),
        .stall           (stall),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .flush_ex_mem    (flush_ex_mem),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {stall, bubble_ex, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Packs {stall, bubble, fl_if_id, fl_id_ex, fl_ex_mem, fwd_a, fwd_b}.
    function automatic logic [8:0] e(input logic s, input logic b, input logic fi,
                                     input logic fd, input logic fm,
                                     input logic [1:0] fa, input logic [1:0] fb);
        return {s, b, fi, fd, fm, fa, fb};
    endfunction

    task automatic clr();
        rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0; rd_ex = '0;
        rd_mem = '0; rd_wb = '0; regwrite_mem = 1'b0; regwrite_wb = 1'b0;
        from_IMEM_ID_EX = 7'b0010011; from_IMEM_EX_MEM = 7'b0010011;
        from_assertion = 1'b0; ext_stall = 1'b0;
    endtask

    task automatic load_use();
        from_IMEM_ID_EX = 7'b0000011;
        rd_ex  = 5'd7;
        rs2_id = 5'd7;
    endtask

    // Push the expectation with the stimulus, compare when outputs settle.
    task automatic run_cycle(input string tag, input logic [8:0] exp);
        logic [8:0] want;
        sb.push_back(exp);
        @(negedge clk);
        want = sb.pop_front();
        check({tag, "_out"}, 32'(obs), 32'(want));
        check({tag, "_scnt"}, stall_cnt, m_stall_cnt);
        check({tag, "_fcnt"}, flush_cnt, m_flush_cnt);
`ifdef HAZARD_PERF_CNT_EN
        if (!reset && want[8] && (m_stall_cnt != 32'hFFFF_FFFF)) m_stall_cnt++;
        if (!reset && want[6] && (m_flush_cnt != 32'hFFFF_FFFF)) m_flush_cnt++;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        m_stall_cnt = '0;
        m_flush_cnt = '0;
        reset = 1'b1;
        clr();
        load_use();
        @(posedge clk);
        #1;
        run_cycle("reset", e(0, 0, 0, 0, 0, 2'b00, 2'b00));
        reset = 1'b0;
        clr();

        // Forwarding: MEM beats WB, WB alone, x0 never forwards.
        rd_mem = 5'd5; regwrite_mem = 1'b1; rd_wb = 5'd5; regwrite_wb = 1'b1;
        rs1_ex = 5'd5; rs2_ex = 5'd5;
        run_cycle("fwd_mem", e(0, 0, 0, 0, 0, 2'b10, 2'b10));
        regwrite_mem = 1'b0;
        run_cycle("fwd_wb", e(0, 0, 0, 0, 0, 2'b01, 2'b01));
        rs2_ex = 5'd6;
        run_cycle("fwd_split", e(0, 0, 0, 0, 0, 2'b01, 2'b00));
        rs1_ex = 5'd0; rd_mem = 5'd0; regwrite_mem = 1'b1; rd_wb = 5'd0;
        run_cycle("fwd_x0", e(0, 0, 0, 0, 0, 2'b00, 2'b00));
        clr();

        // Load-use with LOAD_LATENCY=3: three stall/bubble cycles then idle.
        load_use();
        run_cycle("lu_c0", e(1, 1, 0, 0, 0, 2'b00, 2'b00));
        clr();
        run_cycle("lu_c1", e(1, 1, 0, 0, 0, 2'b00, 2'b00));
        run_cycle("lu_c2", e(1, 1, 0, 0, 0, 2'b00, 2'b00));
        run_cycle("lu_done", e(0, 0, 0, 0, 0, 2'b00, 2'b00));
        run_cycle("lu_idle", e(0, 0, 0, 0, 0, 2'b00, 2'b00));

        // Branch kill on the second stall cycle aborts the stall.
        load_use();
        run_cycle("kill_c0", e(1, 1, 0, 0, 0, 2'b00, 2'b00));
        clr();
        from_IMEM_EX_MEM = 7'b1100011; from_assertion = 1'b1;
        run_cycle("kill_hit", e(0, 0, 1, 1, 1, 2'b00, 2'b00));
        clr();
        run_cycle("kill_after", e(0, 0, 0, 0, 0, 2'b00, 2'b00));
        from_IMEM_EX_MEM = 7'b1100011; from_assertion = 1'b0;
        run_cycle("br_not_taken", e(0, 0, 0, 0, 0, 2'b00, 2'b00));
        clr();

        // Freeze four cycles in LD_STALL (counter 2); two stall cycles remain.
        load_use();
        run_cycle("frz_c0", e(1, 1, 0, 0, 0, 2'b00, 2'b00));
        clr();
        ext_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_cycle($sformatf("frz_hold%0d", i), e(1, 0, 0, 0, 0, 2'b00, 2'b00));
        end
        ext_stall = 1'b0;
        run_cycle("frz_rel1", e(1, 1, 0, 0, 0, 2'b00, 2'b00));
        run_cycle("frz_rel2", e(1, 1, 0, 0, 0, 2'b00, 2'b00));
        run_cycle("frz_done", e(0, 0, 0, 0, 0, 2'b00, 2'b00));

        // JALR flushes IF/ID and ID/EX only.
        from_IMEM_ID_EX = 7'b1100111;
        run_cycle("jalr", e(0, 0, 1, 1, 0, 2'b00, 2'b00));
        clr();
        run_cycle("jalr_after", e(0, 0, 0, 0, 0, 2'b00, 2'b00));

        // Kill held through a freeze is ignored, then acted on at release.
        ext_stall = 1'b1; from_IMEM_EX_MEM = 7'b1100011; from_assertion = 1'b1;
        run_cycle("frz_kill", e(1, 0, 0, 0, 0, 2'b00, 2'b00));
        ext_stall = 1'b0;
        run_cycle("frz_kill_rel", e(0, 0, 1, 1, 1, 2'b00, 2'b00));
        clr();

        // Jump wins over a simultaneous load-use.
        from_IMEM_ID_EX = 7'b1101111; rd_ex = 5'd7; rs1_id = 5'd7;
        run_cycle("jal_vs_lu", e(0, 0, 1, 1, 0, 2'b00, 2'b00));
        clr();
        run_cycle("jal_after", e(0, 0, 0, 0, 0, 2'b00, 2'b00));

        // Reset in the middle of LD_STALL leaves nothing behind.
        load_use();
        run_cycle("rst_c0", e(1, 1, 0, 0, 0, 2'b00, 2'b00));
        clr();
        run_cycle("rst_c1", e(1, 1, 0, 0, 0, 2'b00, 2'b00));
        reset = 1'b1;
        m_stall_cnt = '0;
        m_flush_cnt = '0;
        run_cycle("rst_mid", e(0, 0, 0, 0, 0, 2'b00, 2'b00));
        reset = 1'b0;
        run_cycle("rst_post1", e(0, 0, 0, 0, 0, 2'b00, 2'b00));
        run_cycle("rst_post2", e(0, 0, 0, 0, 0, 2'b00, 2'b00));

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
